seg7_count_decoder: RTL and testbench
=====================================

Name: seg7_count_decoder

Overview:
Receive-side counterpart of the seven-segment count display. Samples two active-low digit patterns (units, tens) and decodes them back to a 4-bit count 0..15. Filters glitches with a stability requirement and checks that successive committed values differ by exactly ±1 mod 16. Used as an on-chip self-check monitor beside the display path and as the bench's scoreboard front end.

Parameters:
STABLE, 2, consecutive identical legal samples required before a value is committed (1..15)
ERR_W, 8, width of saturating error counter

Ports:
CLK  in  1  system clock, all logic on rising edge
RST  in  1  synchronous reset, active-high
SAMPLE  in  1  sample enable; patterns examined only in cycles with SAMPLE=1
SEG0  in  [0:6]  units digit, segments a..g, active-low (0 = lit)
SEG1  in  [0:6]  tens digit, same format
NUM  out  [3:0]  last committed count
VALID  out  1  NUM holds a committed value
NEW  out  1  one-cycle pulse: NUM committed this cycle
DIR  out  1  direction of last legal step, 1 = up, 0 = down
STEP_OK  out  1  one-cycle pulse with NEW when step was legal ±1
ERR  out  1  one-cycle pulse: illegal pattern or illegal step
ERR_CNT  out  [ERR_W-1:0]  saturating count of ERR pulses

Behaviour:
- Reset (RST=1 at an edge): NUM=0, VALID=0, NEW=0, DIR=0, STEP_OK=0, ERR=0, ERR_CNT=0, candidate cleared, stability count=0, FSM=EMPTY. RST overrides SAMPLE in the same cycle.
- Digit table (SEG bits a..g): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100. Any other pattern is illegal.
- Legal pair: SEG1 ∈ {0,1}, SEG0 any digit, and value = 10*tens + units ≤ 15. Tens=1 with units 6..9, tens ≥2, or any unknown pattern is illegal.
- All outputs are registered and update on the edge that samples SAMPLE=1. NEW, STEP_OK and ERR are high for exactly that following cycle and low in every cycle with SAMPLE=0.
- Illegal sample: ERR=1; ERR_CNT+1, saturating at all-ones; candidate cleared; stability count=0. NUM and VALID are unchanged.
- Legal sample, value == candidate: stability count+1, saturating at STABLE. Legal sample, value != candidate: candidate=value, count=1.
- Commit condition: count reaches STABLE on this sample, and (VALID=0 or candidate != NUM). A value already committed and still held stable does not re-commit.
- FSM states:
  - EMPTY: on commit, NUM=candidate, VALID=1, NEW=1, no step check (STEP_OK=0, ERR=0, DIR unchanged). Go to TRACK.
  - TRACK: on commit, d = (candidate − NUM) mod 16.
    - d=1: DIR=1, STEP_OK=1.
    - d=15: DIR=0, STEP_OK=1.
    - Otherwise: ERR=1, ERR_CNT+1, DIR unchanged.
    - In all cases NUM=candidate, NEW=1, stay in TRACK.
- Wrap-around: 15→0 is a legal up step; 0→15 is a legal down step.
- Only RST returns the FSM to EMPTY. Illegal patterns never clear VALID.
- With STABLE=1, every legal sample differing from NUM commits immediately.

Test Plan:
- Reset then SAMPLE each cycle with SEG1=0000001, SEG0=1001111 (value 1), STABLE=2: NEW pulses on 2nd sample, NUM=1, VALID=1, STEP_OK=0, ERR_CNT=0.
- Up count 1..15 then 0, each value held 2 samples: 15 NEW pulses each with STEP_OK=1, DIR=1; 15→0 step legal; ERR_CNT stays 0.
- Down count 3,2,1,0,15: each commit STEP_OK=1, DIR=0; NUM ends at 15.
- Glitch: value 4 (one sample), 5 (two samples) after NUM=4: no NEW on the single 4, then commit 5 with STEP_OK=1. Repeated 4 samples while NUM=4 produce no NEW.
- Illegal inputs: SEG1=1001111 with SEG0=0100000 (16), then SEG0=1111111: ERR pulses each, ERR_CNT=2, NUM/VALID unchanged. Then jump NUM 2→7: ERR pulse, ERR_CNT=3, NUM=7, DIR unchanged.
- Saturation and reset: ERR_W=2, five errors: ERR_CNT=3. Assert RST together with SAMPLE and a legal pattern: all outputs return to reset values, FSM=EMPTY, and the next commit has STEP_OK=0.

Source files
------------

// File: rtl/seg7_count_decoder.sv
// Decodes two active-low seven-segment digits back to a 0..15 count, filters
// glitches with a stability window and flags any committed step other than +/-1.
module seg7_count_decoder #(
    parameter int STABLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SAMPLE,
    input  logic [0:6]       SEG0,
    input  logic [0:6]       SEG1,
    output logic [3:0]       NUM,
    output logic             VALID,
    output logic             NEW,
    output logic             DIR,
    output logic             STEP_OK,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             DBG_STATE
);

    typedef enum logic {EMPTY = 1'b0, TRACK = 1'b1} state_t;

    localparam logic [3:0] STABLE_C = 4'(STABLE);

    // Returns {legal, digit}; digit is meaningless when legal is 0.
    function automatic logic [4:0] decode_digit(input logic [0:6] seg);
        case (seg)
            7'b0000001: decode_digit = {1'b1, 4'd0};
            7'b1001111: decode_digit = {1'b1, 4'd1};
            7'b0010010: decode_digit = {1'b1, 4'd2};
            7'b0000110: decode_digit = {1'b1, 4'd3};
            7'b1001100: decode_digit = {1'b1, 4'd4};
            7'b0100100: decode_digit = {1'b1, 4'd5};
            7'b0100000: decode_digit = {1'b1, 4'd6};
            7'b0001111: decode_digit = {1'b1, 4'd7};
            7'b0000000: decode_digit = {1'b1, 4'd8};
            7'b0000100: decode_digit = {1'b1, 4'd9};
            default:    decode_digit = {1'b0, 4'd0};
        endcase
    endfunction

    state_t           state_q;
    logic [3:0]       num_q;
    logic             valid_q;
    logic             new_q;
    logic             dir_q;
    logic             step_ok_q;
    logic             err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [3:0]       cand_q;
    logic             cand_valid_q;
    logic [3:0]       stab_cnt_q;

    logic [4:0]       units_d;
    logic [4:0]       tens_d;
    logic             legal_d;
    logic [3:0]       value_d;
    logic [3:0]       stab_cnt_d;
    logic             commit_d;
    logic [3:0]       diff_d;
    logic [ERR_W-1:0] err_cnt_inc_d;

    always_comb begin
        units_d       = decode_digit(SEG0);
        tens_d        = decode_digit(SEG1);
        value_d       = tens_d[0] ? (units_d[3:0] + 4'd10) : units_d[3:0];
        // Tens digit may only be 0 or 1, and 1x is only legal up to 15.
        legal_d       = units_d[4] && tens_d[4] && (tens_d[3:1] == 3'd0) &&
                        (!tens_d[0] || (units_d[3:0] <= 4'd5));
        if (cand_valid_q && (value_d == cand_q)) begin
            stab_cnt_d = (stab_cnt_q >= STABLE_C) ? STABLE_C : stab_cnt_q + 4'd1;
        end else begin
            stab_cnt_d = 4'd1;
        end
        commit_d      = legal_d && (stab_cnt_d == STABLE_C) &&
                        (!valid_q || (value_d != num_q));
        diff_d        = value_d - num_q;
        err_cnt_inc_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= EMPTY;
            num_q        <= 4'd0;
            valid_q      <= 1'b0;
            new_q        <= 1'b0;
            dir_q        <= 1'b0;
            step_ok_q    <= 1'b0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
            cand_q       <= 4'd0;
            cand_valid_q <= 1'b0;
            stab_cnt_q   <= 4'd0;
        end else begin
            new_q     <= 1'b0;
            step_ok_q <= 1'b0;
            err_q     <= 1'b0;
            if (SAMPLE) begin
                if (!legal_d) begin
                    err_q        <= 1'b1;
                    err_cnt_q    <= err_cnt_inc_d;
                    cand_valid_q <= 1'b0;
                    stab_cnt_q   <= 4'd0;
                end else begin
                    cand_q       <= value_d;
                    cand_valid_q <= 1'b1;
                    stab_cnt_q   <= stab_cnt_d;
                    if (commit_d) begin
                        num_q   <= value_d;
                        valid_q <= 1'b1;
                        new_q   <= 1'b1;
                        state_q <= TRACK;
                        // The first commit after reset has no predecessor to check.
                        if (state_q == TRACK) begin
                            if (diff_d == 4'd1) begin
                                dir_q     <= 1'b1;
                                step_ok_q <= 1'b1;
                            end else if (diff_d == 4'd15) begin
                                dir_q     <= 1'b0;
                                step_ok_q <= 1'b1;
                            end else begin
                                err_q     <= 1'b1;
                                err_cnt_q <= err_cnt_inc_d;
                            end
                        end
                    end
                end
            end
        end
    end

    assign NUM       = num_q;
    assign VALID     = valid_q;
    assign NEW       = new_q;
    assign DIR       = dir_q;
    assign STEP_OK   = step_ok_q;
    assign ERR       = err_q;
    assign ERR_CNT   = err_cnt_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_seg7_count_decoder.sv
// Bench for seg7_count_decoder: two instances (STABLE=2/ERR_W=8 and
// STABLE=1/ERR_W=2) driven in lockstep and compared against a value-level model.
module tb_seg7_count_decoder;

    logic       clk;
    logic       rst;
    logic       sample;
    logic [0:6] seg0;
    logic [0:6] seg1;

    logic [3:0] num0, num1;
    logic       valid0, valid1, new0, new1, dir0, dir1;
    logic       step_ok0, step_ok1, err0, err1, state0, state1;
    logic [7:0] err_cnt0;
    logic [1:0] err_cnt1;

    int errors = 0;
    int checks = 0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg7_count_decoder #(.STABLE(2), .ERR_W(8)) u_dut0 (
        .CLK(clk), .RST(rst), .SAMPLE(sample), .SEG0(seg0), .SEG1(seg1),
        .NUM(num0), .VALID(valid0), .NEW(new0), .DIR(dir0), .STEP_OK(step_ok0),
        .ERR(err0), .ERR_CNT(err_cnt0), .DBG_STATE(state0)
    );

    seg7_count_decoder #(.STABLE(1), .ERR_W(2)) u_dut1 (
        .CLK(clk), .RST(rst), .SAMPLE(sample), .SEG0(seg0), .SEG1(seg1),
        .NUM(num1), .VALID(valid1), .NEW(new1), .DIR(dir1), .STEP_OK(step_ok1),
        .ERR(err1), .ERR_CNT(err_cnt1), .DBG_STATE(state1)
    );

    // digit glyphs, index = digit value, bit order a..g, 0 = lit
    logic [0:6] glyph [10];
    initial begin
        glyph[0] = 7'b0000001; glyph[1] = 7'b1001111; glyph[2] = 7'b0010010;
        glyph[3] = 7'b0000110; glyph[4] = 7'b1001100; glyph[5] = 7'b0100100;
        glyph[6] = 7'b0100000; glyph[7] = 7'b0001111; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0000100;
    end

    // reference model state, one slot per instance
    int m_stable [2];
    int m_errmax [2];
    int m_cand   [2];  // -1 = no candidate
    int m_cnt    [2];
    int m_num    [2];
    int m_valid  [2];
    int m_dir    [2];
    int m_errcnt [2];
    int m_new    [2];
    int m_stepok [2];
    int m_err    [2];

    function automatic int glyph_value(logic [0:6] p);
        for (int i = 0; i < 10; i++) if (glyph[i] == p) return i;
        return -1;
    endfunction

    function automatic void model_reset(int k);
        m_cand[k] = -1; m_cnt[k] = 0; m_num[k] = 0; m_valid[k] = 0;
        m_dir[k] = 0; m_errcnt[k] = 0; m_new[k] = 0; m_stepok[k] = 0; m_err[k] = 0;
    endfunction

    function automatic void model_error(int k);
        m_err[k] = 1;
        if (m_errcnt[k] < m_errmax[k]) m_errcnt[k]++;
    endfunction

    function automatic void model_step(int k, bit r, bit s, logic [0:6] t_p, logic [0:6] u_p);
        int t, u, v, d;
        if (r) begin
            model_reset(k);
            return;
        end
        m_new[k] = 0; m_stepok[k] = 0; m_err[k] = 0;
        if (!s) return;
        t = glyph_value(t_p);
        u = glyph_value(u_p);
        v = 10 * t + u;
        if (t < 0 || u < 0 || t > 1 || v > 15) begin
            model_error(k);
            m_cand[k] = -1;
            m_cnt[k] = 0;
            return;
        end
        if (v == m_cand[k]) m_cnt[k] = (m_cnt[k] + 1 > m_stable[k]) ? m_stable[k] : m_cnt[k] + 1;
        else begin
            m_cand[k] = v;
            m_cnt[k] = 1;
        end
        if (m_cnt[k] == m_stable[k] && (m_valid[k] == 0 || v != m_num[k])) begin
            if (m_valid[k] != 0) begin
                d = (v - m_num[k] + 16) % 16;
                if (d == 1) begin m_dir[k] = 1; m_stepok[k] = 1; end
                else if (d == 15) begin m_dir[k] = 0; m_stepok[k] = 1; end
                else model_error(k);
            end
            m_num[k] = v;
            m_valid[k] = 1;
            m_new[k] = 1;
        end
    endfunction

    task automatic check(string tag, int obs, int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("dut0.num", int'(num0), m_num[0]);
        check("dut0.valid", int'(valid0), m_valid[0]);
        check("dut0.new", int'(new0), m_new[0]);
        check("dut0.dir", int'(dir0), m_dir[0]);
        check("dut0.step_ok", int'(step_ok0), m_stepok[0]);
        check("dut0.err", int'(err0), m_err[0]);
        check("dut0.err_cnt", int'(err_cnt0), m_errcnt[0]);
        check("dut0.state", int'(state0), m_valid[0]);
        check("dut1.num", int'(num1), m_num[1]);
        check("dut1.valid", int'(valid1), m_valid[1]);
        check("dut1.new", int'(new1), m_new[1]);
        check("dut1.dir", int'(dir1), m_dir[1]);
        check("dut1.step_ok", int'(step_ok1), m_stepok[1]);
        check("dut1.err", int'(err1), m_err[1]);
        check("dut1.err_cnt", int'(err_cnt1), m_errcnt[1]);
        check("dut1.state", int'(state1), m_valid[1]);
    endtask

    // driver: apply one cycle of inputs, advance the model, compare after the edge
    task automatic drive(bit r, bit s, logic [0:6] t_p, logic [0:6] u_p);
        @(negedge clk);
        rst = r; sample = s; seg1 = t_p; seg0 = u_p;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, r, s, t_p, u_p);
        #1;
        check_all();
    endtask

    task automatic put(int v, int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, glyph[v / 10], glyph[v % 10]);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, glyph[0], glyph[0]);
    endtask

    initial begin
        logic [0:6] junk;
        int v;
        m_stable[0] = 2; m_errmax[0] = 255;
        m_stable[1] = 1; m_errmax[1] = 3;
        model_reset(0);
        model_reset(1);
        rst = 1'b1; sample = 1'b0; seg0 = '1; seg1 = '1;

        drive(1'b1, 1'b0, glyph[0], glyph[0]);
        drive(1'b1, 1'b0, glyph[0], glyph[0]);
        check("reset.err_cnt", int'(err_cnt0), 0);

        // first commit, then a full up count with wrap 15 -> 0
        put(1, 2);
        check("first.num", int'(num0), 1);
        check("first.valid", int'(valid0), 1);
        for (int i = 2; i <= 16; i++) put(i % 16, 2);
        idle(2);

        // down count with wrap 0 -> 15
        put(1, 2); put(2, 2); put(3, 2);
        put(2, 2); put(1, 2); put(0, 2); put(15, 2);
        check("down.num", int'(num0), 15);

        // glitch filtering around NUM=4
        put(0, 2); put(1, 2); put(2, 2); put(3, 2); put(4, 2);
        put(4, 1); put(5, 2);
        put(4, 2); put(4, 3);
        idle(1);

        // illegal patterns, then an illegal jump 2 -> 7
        drive(1'b0, 1'b1, glyph[1], glyph[6]);
        drive(1'b0, 1'b1, glyph[1], 7'b1111111);
        put(3, 2); put(2, 2); put(7, 2);
        check("jump.num", int'(num0), 7);

        // more errors to saturate the narrow counter
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 7'b1111111, glyph[i]);
        check("sat.err_cnt1", int'(err_cnt1), 3);

        // reset together with a legal sample, then a fresh first commit
        drive(1'b1, 1'b1, glyph[0], glyph[9]);
        check("rst.state", int'(state0), 0);
        put(9, 2);
        check("rst.step_ok", int'(step_ok0), 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                drive(1'b1, 1'($urandom_range(0, 1)), glyph[0], glyph[1]);
            end else if ($urandom_range(0, 4) == 0) begin
                drive(1'b0, 1'b0, glyph[$urandom_range(0, 9)], glyph[$urandom_range(0, 9)]);
            end else begin
                case ($urandom_range(0, 9))
                    0: begin
                        junk = 7'($urandom);
                        drive(1'b0, 1'b1, glyph[$urandom_range(0, 1)], junk);
                    end
                    1: drive(1'b0, 1'b1, glyph[$urandom_range(0, 9)], glyph[$urandom_range(0, 9)]);
                    2: drive(1'b0, 1'b1, glyph[1], glyph[$urandom_range(6, 9)]);
                    default: begin
                        v = (m_num[0] + 16 + int'($urandom_range(0, 2)) - 1) % 16;
                        put(v, $urandom_range(1, 3));
                    end
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
